uart_tx: RTL and testbench

Buffered UART transmitter, 8 data bits, no parity, 1 stop bit (8N1), LSB first. It is the sending counterpart of the board's UART receiver and drives the serial line that a `uartrx` instance samples. CPU-side logic pushes bytes through a valid/ready handshake into a small internal FIFO. The block serialises them back-to-back at a fixed baud rate derived from the 50 MHz clock.

---
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO accepts bytes over valid/ready.
// A four-state FSM sends the queued bytes LSB first at CLK_HZ/BAUD_RATE clocks per bit.
module uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD_RATE  = 9650,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk50Mhz,
  input  logic                          reset,
  input  logic [7:0]                    txData,
  input  logic                          txValid,
  output logic                          txReady,
  output logic                          portTX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [15:0]        baud_cnt_q, baud_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, pop, baud_done;
  logic [7:0] head;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Readiness comes from the registered count only, so a pop in the same
  // cycle never opens room for a push into a full FIFO.
  assign txReady    = ~reset & ~fifo_full;
  assign push       = txValid & txReady;
  assign head       = mem_q[rd_ptr_q];
  assign baud_done  = (baud_cnt_q == 16'(CLKS_PER_BIT - 1));

  assign portTX    = tx_q;
  assign busy      = (state_q != IDLE) | ~fifo_empty;
  assign fifoCount = count_q;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_done ? 16'd0 : baud_cnt_q + 16'd1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = 16'd0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk50Mhz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the storage array is not reset; the cleared pointers and count
  // make stale entries unreachable, and this keeps it mappable to RAM.
  always_ff @(posedge clk50Mhz) begin
    if (push) mem_q[wr_ptr_q] <= txData;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: small-baud instance for framing/FIFO cases and
// a default-parameter instance decoded by a mid-bit sampling receiver.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB     = 16;
  localparam int DEF_CPB = 50000000 / 9650;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       port_tx;
  logic       busy;
  logic [2:0] fifo_count;

  logic [7:0] def_data;
  logic       def_valid;
  logic       def_ready;
  logic       def_tx;
  logic       def_busy;
  logic [2:0] def_count;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  uart_tx #(.CLK_HZ(160), .BAUD_RATE(10), .FIFO_DEPTH(4)) u_dut (
    .clk50Mhz (clk),
    .reset    (rst),
    .txData   (tx_data),
    .txValid  (tx_valid),
    .txReady  (tx_ready),
    .portTX   (port_tx),
    .busy     (busy),
    .fifoCount(fifo_count)
  );

  uart_tx u_dut_def (
    .clk50Mhz (clk),
    .reset    (rst),
    .txData   (def_data),
    .txValid  (def_valid),
    .txReady  (def_ready),
    .portTX   (def_tx),
    .busy     (def_busy),
    .fifoCount(def_count)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at a negedge that lies 'skip' cycles into the start bit; returns
  // at the negedge one cycle past the last stop-bit cycle.
  task automatic check_frame(input logic [7:0] b, input int skip, input string tag);
    logic [9:0] bits;
    int hits;
    int first;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      hits  = 0;
      first = (k == 0) ? skip : 0;
      for (int c = first; c < CPB; c++) begin
        if (port_tx === bits[k]) hits++;
        @(negedge clk);
      end
      check($sformatf("%s bit%0d", tag, k), hits, CPB - first);
    end
  endtask

  task automatic send_single(input logic [7:0] b, input string tag);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, " count_after_accept"}, fifo_count, 1);
    check({tag, " busy_after_accept"}, busy, 1);
    check({tag, " line_high_before_pop"}, port_tx, 1);
    @(negedge clk);
    check({tag, " start_low"}, port_tx, 0);
    check({tag, " count_after_pop"}, fifo_count, 0);
    check_frame(b, 0, tag);
    check({tag, " busy_end"}, busy, 0);
    check({tag, " line_idle"}, port_tx, 1);
  endtask

  // Streams incrementing bytes until txReady drops; leaves the bench at the
  // negedge where it was first seen low (start bit cycle 3).
  task automatic fill_fifo(input logic [7:0] first_byte, input string tag);
    logic [7:0] b;
    logic       seen_full;
    b = first_byte;
    seen_full = 1'b0;
    for (int i = 0; i < 20 && !seen_full; i++) begin
      tx_data  = b;
      tx_valid = 1'b1;
      if (!tx_ready) seen_full = 1'b1;
      else begin
        @(negedge clk);
        b = b + 8'd1;
      end
    end
    tx_valid = 1'b0;
    check({tag, " ready_dropped"}, seen_full, 1);
    check({tag, " count_at_full"}, fifo_count, 4);
    check({tag, " bytes_accepted"}, b - first_byte, 5);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] peak;
    logic [7:0] rx;
    int         hits;
    int         wait_cnt;

    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    def_data = 8'h00; def_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst portTX", port_tx, 1);
    check("rst txReady", tx_ready, 0);
    check("rst busy", busy, 0);
    check("rst fifoCount", fifo_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst txReady", tx_ready, 1);

    // 1: single byte
    send_single(8'h56, "t1");

    // 2: three bytes on consecutive cycles, contiguous frames
    peak = 8'd0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    if (fifo_count > peak) peak = 8'(fifo_count);
    tx_data = 8'h00;
    @(negedge clk);
    if (fifo_count > peak) peak = 8'(fifo_count);
    tx_data = 8'hFF;
    @(negedge clk);
    if (fifo_count > peak) peak = 8'(fifo_count);
    tx_valid = 1'b0;
    check("t2 peak_count", peak, 2);
    check_frame(8'hA5, 1, "t2a");
    check_frame(8'h00, 0, "t2b");
    check_frame(8'hFF, 0, "t2c");
    check("t2 busy_end", busy, 0);

    // 3: overflow; line must carry 0x10..0x14 once each
    fill_fifo(8'h10, "t3");
    check_frame(8'h10, 3, "t3_10");
    for (int i = 1; i < 5; i++)
      check_frame(8'h10 + 8'(i), 0, $sformatf("t3_%0h", 8'h10 + i));
    check("t3 busy_end", busy, 0);

    // 4: full FIFO and STOP ending in the same cycle
    fill_fifo(8'h20, "t4");
    repeat (156) @(negedge clk);
    check("t4 stop_level", port_tx, 1);
    tx_data = 8'h99; tx_valid = 1'b1;
    check("t4 ready_at_pop", tx_ready, 0);
    @(negedge clk);
    check("t4 count_after_pop", fifo_count, 3);
    check("t4 ready_after_pop", tx_ready, 1);
    check("t4 next_start", port_tx, 0);
    @(negedge clk);
    tx_valid = 1'b0;
    check("t4 count_after_push", fifo_count, 4);
    check_frame(8'h21, 1, "t4_21");
    check_frame(8'h22, 0, "t4_22");
    check_frame(8'h23, 0, "t4_23");
    check_frame(8'h24, 0, "t4_24");
    check_frame(8'h99, 0, "t4_99");
    check("t4 busy_end", busy, 0);

    // 5: reset during data bit 3 (bit 3 of 0x52 is 0)
    tx_data = 8'h52; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h77;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (70) @(negedge clk);
    check("t5 bit3_low", port_tx, 0);
    check("t5 count_before", fifo_count, 1);
    #3 rst = 1'b1;
    #1;
    check("t5 rst_line_high", port_tx, 1);
    check("t5 rst_count", fifo_count, 0);
    check("t5 rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (port_tx === 1'b1 && busy === 1'b0) hits++;
    end
    check("t5 no_glitch", hits, 8);
    send_single(8'h3C, "t5");

    // 6: default parameters, decoded by a mid-bit sampler
    def_data = 8'hC3; def_valid = 1'b1;
    @(negedge clk);
    def_valid = 1'b0;
    wait_cnt = 0;
    while (def_tx !== 1'b0 && wait_cnt < 5) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("t6 start_seen", def_tx, 0);
    repeat (DEF_CPB / 2) @(negedge clk);
    check("t6 start_mid", def_tx, 0);
    rx = 8'h00;
    for (int k = 0; k < 8; k++) begin
      repeat (DEF_CPB) @(negedge clk);
      rx[k] = def_tx;
    end
    repeat (DEF_CPB) @(negedge clk);
    check("t6 stop_mid", def_tx, 1);
    check("t6 rx_data", rx, 8'hC3);
    repeat (DEF_CPB) @(negedge clk);
    check("t6 busy_end", def_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
